// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: default widths, function codes, FSM states.
package alu_pkg;

    localparam int unsigned DefDw  = 8;
    localparam int unsigned DefFsw = 3;

    typedef enum logic [2:0] {
        FsMov = 3'b000,
        FsAdd = 3'b001,
        FsSub = 3'b010,
        FsAbs = 3'b011,
        FsNot = 3'b100,
        FsAnd = 3'b101,
        FsNeg = 3'b110,
        FsHlt = 3'b111
    } alu_fs_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StIssue   = 2'b01,
        StCapture = 2'b10,
        StHalt    = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter; the priority pointer advances past the winner on each update strobe.
module alu_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grant0,
    output logic grant1
);

    logic ptr_q;

    // A lone requester wins regardless of the pointer.
    assign grant0 = req0 & (~req1 | ~ptr_q);
    assign grant1 = req1 & (~req0 | ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (update) begin
            ptr_q <= grant0;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequences one operation at a time from two requesters onto a single shared ALU and
// steers the registered ALU result back to the requester that issued it.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DW  = DefDw,
    parameter int unsigned FSW = DefFsw
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [FSW-1:0] req0_fs,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [FSW-1:0] req1_fs,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           resp0_valid,
    output logic [DW-1:0]  resp0_result,
    output logic           resp1_valid,
    output logic [DW-1:0]  resp1_result,
    output logic           alu_enable,
    output logic [FSW-1:0] alu_fs,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_result,
    output logic           busy,
    output logic           halted
);

    ctrl_state_e    state_q, state_d;
    logic           owner_q, owner_d;
    logic [FSW-1:0] fs_q, fs_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic           grant0, grant1;
    logic           accept;
    logic           in_idle;

    // Arbiter only sees requests while the controller can take one.
    assign in_idle = (state_q == StIdle) & ~rst;

    alu_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0_valid & in_idle),
        .req1   (req1_valid & in_idle),
        .update (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        fs_d       = fs_q;
        a_d        = a_q;
        b_d        = b_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 | grant1) begin
                    accept  = 1'b1;
                    owner_d = grant1;
                    fs_d    = grant1 ? req1_fs : req0_fs;
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    state_d = (fs_d == FsHlt) ? StHalt : StIssue;
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: state_d = StIdle;
            StHalt:    state_d = StHalt;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            fs_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            fs_q    <= fs_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Gating with rst suppresses the pulse when reset lands mid-operation.
    assign alu_enable   = (state_q == StIssue) & ~rst;
    assign resp0_valid  = (state_q == StCapture) & ~owner_q & ~rst;
    assign resp1_valid  = (state_q == StCapture) & owner_q & ~rst;
    assign resp0_result = resp0_valid ? alu_result : '0;
    assign resp1_result = resp1_valid ? alu_result : '0;
    assign alu_fs       = fs_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign busy         = (state_q != StIdle);
    assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a registered behavioural ALU on the datapath side.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_fs, req1_fs, alu_fs;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp0_valid, resp1_valid, alu_enable, busy, halted;
    logic [7:0] resp0_result, resp1_result, alu_a, alu_b, alu_result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_fs      (req0_fs),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_fs      (req1_fs),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .resp0_valid  (resp0_valid),
        .resp0_result (resp0_result),
        .resp1_valid  (resp1_valid),
        .resp1_result (resp1_result),
        .alu_enable   (alu_enable),
        .alu_fs       (alu_fs),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .busy         (busy),
        .halted       (halted)
    );

    // Registered ALU; SUB computes b - a.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result <= 8'h00;
        end else if (alu_enable) begin
            case (alu_fs)
                3'b000:  alu_result <= alu_a;
                3'b001:  alu_result <= alu_a + alu_b;
                3'b010:  alu_result <= alu_b - alu_a;
                3'b011:  alu_result <= alu_a[7] ? -alu_a : alu_a;
                3'b100:  alu_result <= ~alu_a;
                3'b101:  alu_result <= alu_a & alu_b;
                3'b110:  alu_result <= -alu_a;
                default: alu_result <= 8'hEE;
            endcase
        end
    end

    task automatic set0(input logic [2:0] fs, input logic [7:0] a, input logic [7:0] b);
        req0_fs = fs; req0_a = a; req0_b = b; req0_valid = 1'b1;
    endtask

    task automatic set1(input logic [2:0] fs, input logic [7:0] a, input logic [7:0] b);
        req1_fs = fs; req1_a = a; req1_b = b; req1_valid = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set0(3'b001, 8'h01, 8'h02);
        set1(3'b001, 8'h03, 8'h04);
        @(negedge clk);
        @(negedge clk); #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        n_tests++;
        if ({resp0_valid, resp1_valid, alu_enable, busy, halted} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {resp0_valid, resp1_valid, alu_enable, busy, halted});
        end
        n_tests++;
        if ({alu_fs, alu_a, alu_b, resp0_result, resp1_result} !== 35'b0) begin
            n_fail++;
            $display("FAIL reset_data: got fs=%h a=%h b=%h r0=%h r1=%h want all 0",
                     alu_fs, alu_a, alu_b, resp0_result, resp1_result);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        do_reset();
        set0(3'b001, 8'h05, 8'h03); #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready});
        end
        @(negedge clk); req0_valid = 1'b0; #1;
        n_tests++;
        if ({alu_enable, busy, alu_fs, alu_a, alu_b} !== {1'b1, 1'b1, 3'b001, 8'h05, 8'h03}) begin
            n_fail++;
            $display("FAIL add_issue: got en=%b busy=%b fs=%h a=%h b=%h want 1 1 1 05 03",
                     alu_enable, busy, alu_fs, alu_a, alu_b);
        end
        @(negedge clk); #1;
        n_tests++;
        if ({resp0_valid, resp0_result, resp1_valid, alu_enable} !== {1'b1, 8'h08, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_resp: got v0=%b r0=%h v1=%b en=%b want 1 08 0 0",
                     resp0_valid, resp0_result, resp1_valid, alu_enable);
        end
        @(negedge clk); #1;
        n_tests++;
        if ({resp0_valid, resp1_valid, busy, alu_enable} !== 4'b0000) begin
            n_fail++;
            $display("FAIL add_done: got v0=%b v1=%b busy=%b en=%b want 0 0 0 0",
                     resp0_valid, resp1_valid, busy, alu_enable);
        end
    endtask

    task automatic test_both_valid();
        int  nresp = 0;
        bit  drop0 = 1'b0, drop1 = 1'b0, both_ready = 1'b0;
        do_reset();
        set0(3'b010, 8'h01, 8'h09);
        set1(3'b101, 8'hF0, 8'h3C);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
            drop0 = 1'b0; drop1 = 1'b0;
            #1;
            if (req0_ready && req1_ready) both_ready = 1'b1;
            if (req0_ready && req0_valid) drop0 = 1'b1;
            if (req1_ready && req1_valid) drop1 = 1'b1;
            if (resp0_valid) begin
                n_tests++;
                if (nresp != 0 || resp0_result !== 8'h08) begin
                    n_fail++;
                    $display("FAIL both_resp0: got order=%0d r=%h want 0 08", nresp, resp0_result);
                end
                nresp++;
            end
            if (resp1_valid) begin
                n_tests++;
                if (nresp != 1 || resp1_result !== 8'h30) begin
                    n_fail++;
                    $display("FAIL both_resp1: got order=%0d r=%h want 1 30", nresp, resp1_result);
                end
                nresp++;
            end
        end
        n_tests++;
        if (both_ready || nresp != 2) begin
            n_fail++;
            $display("FAIL both_summary: got both_ready=%b nresp=%0d want 0 2", both_ready, nresp);
        end
    endtask

    task automatic test_alternate();
        int gcnt = 0, rcnt = 0;
        bit exp0;
        do_reset();
        set0(3'b000, 8'h11, 8'h00);
        set1(3'b000, 8'h22, 8'h00);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (req0_ready || req1_ready) begin
                if (gcnt == 6) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end else begin
                    exp0 = (gcnt % 2 == 0);
                    n_tests++;
                    if ({req0_ready, req1_ready} !== {exp0, ~exp0}) begin
                        n_fail++;
                        $display("FAIL alt_grant%0d: got %b want %b", gcnt,
                                 {req0_ready, req1_ready}, {exp0, ~exp0});
                    end
                    gcnt++;
                end
            end
            if (resp0_valid || resp1_valid) begin
                exp0 = (rcnt % 2 == 0);
                n_tests++;
                if ({resp0_valid, resp1_valid} !== {exp0, ~exp0} ||
                    (exp0 ? resp0_result : resp1_result) !== (exp0 ? 8'h11 : 8'h22)) begin
                    n_fail++;
                    $display("FAIL alt_resp%0d: got v=%b r0=%h r1=%h want v=%b r=%h", rcnt,
                             {resp0_valid, resp1_valid}, resp0_result, resp1_result,
                             {exp0, ~exp0}, exp0 ? 8'h11 : 8'h22);
                end
                rcnt++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_tests++;
        if (gcnt != 6 || rcnt != 6) begin
            n_fail++; $display("FAIL alt_count: got grants=%0d resps=%0d want 6 6", gcnt, rcnt);
        end
    endtask

    task automatic test_halt();
        bit bad = 1'b0;
        do_reset();
        set1(3'b111, 8'h00, 8'h00); #1;
        n_tests++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL halt_accept: got ready1=%b want 1", req1_ready);
        end
        @(negedge clk); req1_valid = 1'b0; #1;
        n_tests++;
        if ({halted, busy, alu_enable} !== 3'b110) begin
            n_fail++;
            $display("FAIL halt_state: got halted=%b busy=%b en=%b want 1 1 0",
                     halted, busy, alu_enable);
        end
        set0(3'b001, 8'h01, 8'h01);
        set1(3'b001, 8'h02, 8'h02);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (req0_ready || req1_ready || alu_enable || resp0_valid || resp1_valid || !halted)
                bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL halt_sticky: got activity=1 want 0");
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; #1;
        n_tests++;
        if ({halted, busy} !== 2'b00) begin
            n_fail++; $display("FAIL halt_clear: got halted=%b busy=%b want 0 0", halted, busy);
        end
    endtask

    task automatic test_reset_capture();
        bit bad = 1'b0;
        do_reset();
        set0(3'b001, 8'h05, 8'h03);
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        n_tests++;
        if ({resp0_valid, resp1_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstcap_pulse: got v=%b want 00", {resp0_valid, resp1_valid});
        end
        @(negedge clk); rst = 1'b0; #1;
        n_tests++;
        if ({busy, alu_enable, resp0_valid, resp1_valid, alu_fs, alu_a, alu_b} !== 23'b0) begin
            n_fail++;
            $display("FAIL rstcap_outputs: got busy=%b en=%b fs=%h a=%h b=%h want all 0",
                     busy, alu_enable, alu_fs, alu_a, alu_b);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (resp0_valid || resp1_valid || alu_enable) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL rstcap_quiet: got activity=1 want 0");
        end
        set0(3'b000, 8'h5A, 8'h00);
        set1(3'b000, 8'hA5, 8'h00); #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rstcap_ptr: got %b want 10", {req0_ready, req1_ready});
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if ({resp0_valid, resp0_result} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL rstcap_next: got v0=%b r0=%h want 1 5a", resp0_valid, resp0_result);
        end
    endtask

    task automatic test_withdrawn();
        bit bad = 1'b0;
        do_reset();
        set0(3'b001, 8'h02, 8'h02);
        @(negedge clk); req0_valid = 1'b0;
        set1(3'b000, 8'h77, 8'h00); #1;
        n_tests++;
        if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL wd_issue_ready: got %b want 0", req1_ready);
        end
        @(negedge clk); #1;
        n_tests++;
        if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL wd_capture_ready: got %b want 0", req1_ready);
        end
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (alu_enable || resp1_valid || busy) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL wd_ignored: got activity=1 want 0");
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_fs = '0; req0_a = '0; req0_b = '0;
        req1_fs = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_single_add();
        test_both_valid();
        test_alternate();
        test_halt();
        test_reset_capture();
        test_withdrawn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares the single 8-bit ALU datapath between two requesters (port 0 and port 1). Accepts one operation at a time under a valid/ready handshake, arbitrates round-robin, drives the ALU enable/function/operand inputs for exactly one cycle, and returns the registered ALU result to the winning requester as a one-cycle response pulse. A HLT function code (3'b111) is never issued to the ALU; it parks the controller in a halted state until reset.

## Interface
- DW, 8, operand/result width
- FSW, 3, function-select width
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_fs / req1_fs  in  FSW  function code (MOV, ADD, SUB, ABS, NOT, AND, NEG, HLT)
- req0_a, req0_b / req1_a, req1_b  in  DW  operands A and B
- resp0_valid / resp1_valid  out  1  one-cycle result pulse, no backpressure
- resp0_result / resp1_result  out  DW  result, valid only while resp*_valid
- alu_enable  out  1  ALU calculate enable
- alu_fs  out  FSW  ALU function select
- alu_a / alu_b  out  DW  ALU operands
- alu_result  in  DW  registered ALU output
- busy  out  1  operation in flight (state != IDLE)
- halted  out  1  HLT accepted; sticky until RST

## Operation
- States: IDLE, ISSUE, CAPTURE, HALT.
- IDLE: arbiter picks one valid requester; only the winner sees ready=1 (loser ready=0). On handshake, latch fs/a/b and owner id; fs!=HLT -> ISSUE; fs==HLT -> HALT.
- ISSUE: alu_enable=1, alu_fs/alu_a/alu_b = latched values -> CAPTURE.
- CAPTURE: resp<owner>_valid=1, resp<owner>_result=alu_result; other response valid=0 -> IDLE.
- HALT: all ready=0, alu_enable=0, halted=1; exits only on RST. HLT request itself produces no response.
- Arbitration: round-robin, 1-bit priority pointer. Reset pointer = port 0. Pointer moves to the port not granted after every accepted request (including HLT). Single valid requester wins regardless of pointer.
- alu_fs/alu_a/alu_b hold latched values in all states; alu_enable high only in ISSUE.
- No arithmetic in this block; DW-bit values are passed through unchanged.

## Timing
- Reset values: ready0/1=0 during RST cycle, then per IDLE rule; resp*_valid=0, resp*_result=0, alu_enable=0, alu_fs=0, alu_a=alu_b=0, busy=0, halted=0, state=IDLE, pointer=0.
- Accept at edge T -> ISSUE cycle T+1 (ALU captures at end of T+1) -> CAPTURE cycle T+2 with resp valid -> IDLE at T+3, next accept possible at end of T+3. Throughput: one op per 3 cycles.
- Simultaneous valid on both ports: pointer holder wins; loser must hold request, served next IDLE.
- Requester may drop valid without handshake; no effect.
- Request valid during ISSUE/CAPTURE: ready=0, ignored.
- RST mid-operation (ISSUE or CAPTURE): op discarded, no response pulse, all outputs to reset values next cycle.
- RST has priority over every transition including HALT exit.

## Structure
- Shared package alu_pkg: DW/FSW defaults, function-code constants (MOV=000, ADD=001, SUB=010, ABS=011, NOT=100, AND=101, NEG=110, HLT=111), state encoding (IDLE=00, ISSUE=01, CAPTURE=10, HALT=11).
- One sub-module: alu_rr_arbiter (2-way round-robin grant + pointer, update strobe from controller). FSM, operand latch and response steering stay in alu_share_ctrl.

## Test plan
- Port 0 only, ADD a=8'h05 b=8'h03, ALU model returns 8'h08 -> alu_enable high exactly one cycle at T+1, resp0_valid pulse at T+2 with 8'h08, resp1_valid stays 0.
- Both ports valid after reset (p0 SUB a=1 b=9, p1 AND a=F0 b=3C), held -> p0 served first (result 8'h08), then p1 (8'h30); ready never high on both ports together.
- Both ports continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1; each response on the owning port only.
- Port 1 sends HLT -> no alu_enable, no response, halted=1, busy=1; subsequent valid on either port never sees ready until RST, after which halted=0.
- RST asserted during CAPTURE -> no resp pulse that cycle or after; all outputs at reset values; next request processed normally with pointer=0.
- Request valid during ISSUE then withdrawn before IDLE -> never accepted, no ALU activity.
